// File: rtl/pps_sync_v3_if.sv
// pps_sync_v3_if: groups the PPS input, burst configuration and all observable
// status of pps_sync_v3 into one bundle.
//   master : drives SYNC and the configuration, observes the status (testbench / host)
//   slave  : the trigger generator itself
// Signals:
//   SYNC               external PPS, asynchronous to the system clock
//   i_pulse_num        pulses per burst (latched at burst start)
//   i_half_period      high/low time in clocks (latched at burst start, 0 treated as 1)
//   i_holdover_en      allow synthetic PPS edges when the real PPS disappears
//   pps_trig_out       burst output
//   o_pulse_number     0-based index of the current pulse
//   o_half_period_cnt  cycle count inside the current half period
//   o_pps_period       last measured real PPS interval in clocks
//   o_pps_valid        o_pps_period holds a real measurement
//   o_holdover         last burst was started by a synthetic edge
//   o_cstate/o_nstate  current/next FSM state
interface pps_sync_v3_if #(
   parameter int unsigned CW = 32
);
   logic          SYNC;
   logic [CW-1:0] i_pulse_num;
   logic [CW-1:0] i_half_period;
   logic          i_holdover_en;
   logic          pps_trig_out;
   logic [CW-1:0] o_pulse_number;
   logic [CW-1:0] o_half_period_cnt;
   logic [CW-1:0] o_pps_period;
   logic          o_pps_valid;
   logic          o_holdover;
   logic [3:0]    o_cstate;
   logic [3:0]    o_nstate;

   modport master (
      output SYNC, i_pulse_num, i_half_period, i_holdover_en,
      input  pps_trig_out, o_pulse_number, o_half_period_cnt, o_pps_period,
      input  o_pps_valid, o_holdover, o_cstate, o_nstate
   );

   modport slave (
      input  SYNC, i_pulse_num, i_half_period, i_holdover_en,
      output pps_trig_out, o_pulse_number, o_half_period_cnt, o_pps_period,
      output o_pps_valid, o_holdover, o_cstate, o_nstate
   );
endinterface

// File: rtl/pps_sync_v3.sv
// pps_sync_v3: PPS trigger generator with period measurement and holdover.
// A rising edge on the (synchronised) external PPS, or a synthetic edge generated
// while the PPS is missing, starts a burst of i_pulse_num square pulses of
// 2*i_half_period clocks on pps_trig_out. A new start always aborts a running burst.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      pps_sync_v3_if slave modport (PPS in, configuration, status out)
module pps_sync_v3 #(
   parameter int unsigned CW      = 32,
   parameter int unsigned TOL_CYC = 100,
   parameter int unsigned SYNC_FF = 2
) (
   input logic           i_clk,
   input logic           i_rst_n,
   pps_sync_v3_if.slave  bus
);

   typedef enum logic [3:0] {
      StIdle = 4'd0,
      StHigh = 4'd1,
      StLow  = 4'd2,
      StDone = 4'd3
   } state_e;

   localparam int unsigned SW = CW + 2;

   // ---------------------------------------------------------------------------
   // SYNC synchroniser and rising-edge detect
   // ---------------------------------------------------------------------------
   logic [SYNC_FF-1:0] sync_q;
   logic               sync_dly_q;
   logic               real_edge;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q     <= '0;
         sync_dly_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_FF-2:0], bus.SYNC};
         sync_dly_q <= sync_q[SYNC_FF-1];
      end
   end

   assign real_edge = sync_q[SYNC_FF-1] & ~sync_dly_q;

   // ---------------------------------------------------------------------------
   // Period measurement and holdover
   // ---------------------------------------------------------------------------
   logic [CW-1:0] pcnt_q;
   logic [CW-1:0] period_q;
   logic          armed_q;
   logic          valid_q;
   logic          holdover_q;
   logic [SW-1:0] tgt_sum;
   logic [CW-1:0] tgt;
   logic          syn_edge;
   logic          start;

   // Expected PPS time plus tolerance, computed wide so it can saturate.
   assign tgt_sum = SW'(period_q) + SW'(TOL_CYC) - SW'(1);
   assign tgt     = (tgt_sum > SW'({CW{1'b1}})) ? '1 : tgt_sum[CW-1:0];

   // A saturated pcnt means the target is out of reach, so never fire there.
   assign syn_edge = bus.i_holdover_en & valid_q & ~real_edge &
                     (pcnt_q == tgt) & (pcnt_q != '1);

   assign start = real_edge | syn_edge;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pcnt_q     <= '0;
         period_q   <= '0;
         armed_q    <= 1'b0;
         valid_q    <= 1'b0;
         holdover_q <= 1'b0;
      end else if (real_edge) begin
         if (armed_q) begin
            period_q <= pcnt_q + CW'(1);
            valid_q  <= 1'b1;
         end
         armed_q    <= 1'b1;
         pcnt_q     <= '0;
         holdover_q <= 1'b0;
      end else if (syn_edge) begin
         // Restart at TOL_CYC so the next synthetic edge is one period later.
         pcnt_q     <= CW'(TOL_CYC);
         holdover_q <= 1'b1;
      end else if (pcnt_q != '1) begin
         pcnt_q <= pcnt_q + CW'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Burst FSM
   // ---------------------------------------------------------------------------
   state_e        state_q, state_d;
   logic [CW-1:0] np_q, np_d;
   logic [CW-1:0] hp_q, hp_d;
   logic [CW-1:0] pnum_q, pnum_d;
   logic [CW-1:0] hcnt_q, hcnt_d;
   logic          trig_q;

   always_comb begin
      state_d = state_q;
      np_d    = np_q;
      hp_d    = hp_q;
      pnum_d  = pnum_q;
      hcnt_d  = hcnt_q;
      if (start) begin
         // Any start, including one mid-burst, relatches and restarts.
         np_d    = bus.i_pulse_num;
         hp_d    = (bus.i_half_period == '0) ? CW'(1) : bus.i_half_period;
         pnum_d  = '0;
         hcnt_d  = '0;
         state_d = (bus.i_pulse_num == '0) ? StIdle : StHigh;
      end else begin
         unique case (state_q)
            StHigh: begin
               if (hcnt_q == hp_q - CW'(1)) begin
                  hcnt_d  = '0;
                  state_d = StLow;
               end else begin
                  hcnt_d = hcnt_q + CW'(1);
               end
            end
            StLow: begin
               if (hcnt_q == hp_q - CW'(1)) begin
                  hcnt_d = '0;
                  if (pnum_q == np_q - CW'(1)) begin
                     state_d = StDone;
                  end else begin
                     pnum_d  = pnum_q + CW'(1);
                     state_d = StHigh;
                  end
               end else begin
                  hcnt_d = hcnt_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         np_q    <= '0;
         hp_q    <= '0;
         pnum_q  <= '0;
         hcnt_q  <= '0;
         trig_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         np_q    <= np_d;
         hp_q    <= hp_d;
         pnum_q  <= pnum_d;
         hcnt_q  <= hcnt_d;
         trig_q  <= (state_d == StHigh);
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.pps_trig_out      = trig_q;
   assign bus.o_pulse_number    = pnum_q;
   assign bus.o_half_period_cnt = hcnt_q;
   assign bus.o_pps_period      = period_q;
   assign bus.o_pps_valid       = valid_q;
   assign bus.o_holdover        = holdover_q;
   assign bus.o_cstate          = state_q;
   assign bus.o_nstate          = state_d;

endmodule

// File: tb/tb_pps_sync_v3.sv
// Directed testbench for pps_sync_v3 (CW=32, TOL_CYC=100, SYNC_FF=2, 10 ns clock).
// Inputs are driven and outputs sampled 1 ns after the rising clock edge.
module tb_pps_sync_v3;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   pps_sync_v3_if #(.CW(32)) bus ();

   pps_sync_v3 #(
      .CW      (32),
      .TOL_CYC (100),
      .SYNC_FF (2)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Raise SYNC for 3 cycles. Returns one cycle after the detected edge, i.e.
   // the first cycle a burst started by it drives pps_trig_out high.
   task automatic sync_edge();
      bus.SYNC = 1'b1;
      tick(3);
      bus.SYNC = 1'b0;
   endtask

   // Called on the first high cycle of a burst; checks every pulse's timing.
   task automatic measure_burst(input int np, input int hp);
      int hi;
      int lo;
      for (int p = 0; p < np; p++) begin
         check_eq("pulse_index", bus.o_pulse_number, p);
         hi = 0;
         while (bus.pps_trig_out && hi < hp + 5) begin
            hi++;
            tick(1);
         end
         check_eq("high_len", hi, hp);
         lo = 0;
         while (bus.o_cstate == 4'd2 && lo < hp + 5) begin
            lo++;
            tick(1);
         end
         check_eq("low_len", lo, hp);
      end
      check_eq("burst_done_state", bus.o_cstate, 3);
      check_eq("burst_done_trig", bus.pps_trig_out, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      int bad;
      int w;
      n_checks = 0;
      n_fail   = 0;
      bus.SYNC          = 1'b0;
      bus.i_pulse_num   = 32'd5;
      bus.i_half_period = 32'd100;
      bus.i_holdover_en = 1'b0;
      rst_n             = 1'b0;
      tick(3);
      check_eq("rst_trig", bus.pps_trig_out, 0);
      check_eq("rst_cstate", bus.o_cstate, 0);
      check_eq("rst_pnum", bus.o_pulse_number, 0);
      check_eq("rst_period", bus.o_pps_period, 0);
      check_eq("rst_valid", bus.o_pps_valid, 0);
      check_eq("rst_holdover", bus.o_holdover, 0);
      rst_n = 1'b1;
      tick(2);

      // 1: five pulses of 100 clk high / 100 clk low
      bus.SYNC = 1'b1;
      tick(2);
      check_eq("t1_nstate_on_edge", bus.o_nstate, 1);
      check_eq("t1_trig_before", bus.pps_trig_out, 0);
      tick(1);
      bus.SYNC = 1'b0;
      check_eq("t1_trig_rise", bus.pps_trig_out, 1);
      check_eq("t1_hcnt0", bus.o_half_period_cnt, 0);
      measure_burst(5, 100);
      check_eq("t1_valid_first_edge", bus.o_pps_valid, 0);

      // 2/3: three edges 10000 clk apart, then holdover
      do_reset();
      bus.i_pulse_num   = 32'd1;
      bus.i_half_period = 32'd10;
      bus.i_holdover_en = 1'b1;
      sync_edge();
      tick(9997);
      check_eq("t2_valid_after_1", bus.o_pps_valid, 0);
      sync_edge();
      check_eq("t2_valid_after_2", bus.o_pps_valid, 1);
      check_eq("t2_period_after_2", bus.o_pps_period, 10000);
      tick(9997);
      sync_edge();
      check_eq("t2_period_after_3", bus.o_pps_period, 10000);
      check_eq("t2_holdover_real", bus.o_holdover, 0);
      tick(10098);
      check_eq("t3_no_syn_early", bus.o_nstate, 3);
      tick(1);
      check_eq("t3_syn1_nstate", bus.o_nstate, 1);
      tick(1);
      check_eq("t3_syn1_trig", bus.pps_trig_out, 1);
      check_eq("t3_syn1_holdover", bus.o_holdover, 1);
      check_eq("t3_period_kept", bus.o_pps_period, 10000);
      tick(9998);
      check_eq("t3_no_syn2_early", bus.o_nstate, 3);
      tick(1);
      check_eq("t3_syn2_nstate", bus.o_nstate, 1);
      tick(1);
      check_eq("t3_syn2_holdover", bus.o_holdover, 1);
      // Real edge two cycles later: pcnt was 102, so period becomes 103
      sync_edge();
      check_eq("t3_real_clears_holdover", bus.o_holdover, 0);
      check_eq("t3_period_short", bus.o_pps_period, 103);

      // 4: holdover disabled, PPS absent -> FSM stays in DONE
      bus.i_holdover_en = 1'b0;
      tick(30);
      bad = 0;
      for (int i = 0; i < 20000; i++) begin
         if (bus.o_nstate != 4'd3 || bus.pps_trig_out) bad++;
         tick(1);
      end
      check_eq("t4_no_bursts", bad, 0);
      check_eq("t4_holdover_low", bus.o_holdover, 0);

      // 5: restart during pulse 2 of 5
      bus.i_pulse_num   = 32'd5;
      bus.i_half_period = 32'd20;
      sync_edge();
      w = 0;
      while (bus.o_pulse_number != 32'd2 && w < 1000) begin
         w++;
         tick(1);
      end
      check_eq("t5_reached_pulse2", bus.o_pulse_number, 2);
      tick(5);
      bus.SYNC = 1'b1;
      tick(2);
      check_eq("t5_restart_nstate", bus.o_nstate, 1);
      tick(1);
      bus.SYNC = 1'b0;
      check_eq("t5_restart_trig", bus.pps_trig_out, 1);
      check_eq("t5_restart_hcnt", bus.o_half_period_cnt, 0);
      measure_burst(5, 20);

      // 6a: zero pulses -> IDLE, no pulse
      bus.i_pulse_num = 32'd0;
      sync_edge();
      check_eq("t6_np0_state", bus.o_cstate, 0);
      check_eq("t6_np0_trig", bus.pps_trig_out, 0);
      tick(5);
      check_eq("t6_np0_stay", bus.o_cstate, 0);

      // 6b: zero half period -> 1 clk high, 1 clk low
      bus.i_pulse_num   = 32'd2;
      bus.i_half_period = 32'd0;
      sync_edge();
      measure_burst(2, 1);

      // 6c: reset mid-burst clears everything at once
      bus.i_pulse_num   = 32'd5;
      bus.i_half_period = 32'd50;
      sync_edge();
      tick(10);
      check_eq("t6_pre_rst_trig", bus.pps_trig_out, 1);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_trig", bus.pps_trig_out, 0);
      check_eq("t6_rst_cstate", bus.o_cstate, 0);
      check_eq("t6_rst_nstate", bus.o_nstate, 0);
      check_eq("t6_rst_hcnt", bus.o_half_period_cnt, 0);
      check_eq("t6_rst_period", bus.o_pps_period, 0);
      check_eq("t6_rst_valid", bus.o_pps_valid, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
